tl_conflict_monitor: RTL and testbench

TL_CONFLICT_MONITOR -- requirements
Module: tl_conflict_monitor

---
 rtl/tl_conflict_monitor.sv | 138 +++++++++++++
 tb/tb_tl_conflict_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tl_conflict_monitor.sv
// Traffic-light lamp safety monitor: registers lamp commands to the output stage (1-cycle latency),
// forces red flash on conflicts or short yellows until acknowledged. TL_MON_FAULT_COUNT_EN adds FCOUNT.
module tl_conflict_monitor #(
  parameter int MIN_YLW    = 3,
  parameter int DEBOUNCE   = 2,
  parameter int BLINK_HALF = 4
) (
  input  logic       clk,
  input  logic       CLRN,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ACK,
  output logic       OG1,
  output logic       OY1,
  output logic       OR1,
  output logic       OG2,
  output logic       OY2,
  output logic       OR2,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FLASH
`ifdef TL_MON_FAULT_COUNT_EN
  ,
  output logic [7:0] FCOUNT
`endif
);

  localparam logic [3:0] MIN_YLW_C  = 4'(MIN_YLW);
  localparam logic [3:0] DEB_C      = 4'(DEBOUNCE);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);
  localparam logic [5:0] LAMPS_SAFE = 6'b001_001;

  typedef enum logic {S_NORMAL, S_FAULT} state_t;

  state_t     state_q, state_d;
  logic [5:0] lamp_q, lamp_d;  // {OG1, OY1, OR1, OG2, OY2, OR2}
  logic [2:0] code_q, code_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] age1_q, age1_d, age2_q, age2_d;
  logic [7:0] blink_q, blink_d;

  logic [5:0] lamps_in;
  logic [1:0] n1, n2;
  logic       c1, v2, v3, viol, deb_hit, short1, short2, red_d;
  logic [2:0] scode;

  assign lamps_in = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
  assign n1       = 2'(GRN1) + 2'(YLW1) + 2'(RED1);
  assign n2       = 2'(GRN2) + 2'(YLW2) + 2'(RED2);
  assign c1       = (GRN1 | YLW1) & (GRN2 | YLW2);
  assign v2       = (n1 != 2'd1);
  assign v3       = (n2 != 2'd1);
  assign viol     = c1 | v2 | v3;
  assign scode    = c1 ? 3'd1 : v2 ? 3'd2 : v3 ? 3'd3 : 3'd0;
  assign deb_hit  = viol && (({1'b0, deb_q} + 5'd1) >= {1'b0, DEB_C});

  // A non-zero age means yellow was lit on the previous edge.
  assign short1   = (age1_q != 4'd0) && !YLW1 && (age1_q < MIN_YLW_C);
  assign short2   = (age2_q != 4'd0) && !YLW2 && (age2_q < MIN_YLW_C);

  always_comb begin
    state_d = state_q;
    lamp_d  = lamps_in;
    code_d  = code_q;
    blink_d = blink_q;
    red_d   = lamp_q[3];
    deb_d   = viol ? ((deb_q == DEB_C) ? deb_q : deb_q + 4'd1) : 4'd0;
    age1_d  = YLW1 ? ((age1_q == MIN_YLW_C) ? age1_q : age1_q + 4'd1) : 4'd0;
    age2_d  = YLW2 ? ((age2_q == MIN_YLW_C) ? age2_q : age2_q + 4'd1) : 4'd0;

    case (state_q)
      S_NORMAL: begin
        if (deb_hit || short1 || short2) begin
          state_d = S_FAULT;
          code_d  = deb_hit ? scode : 3'd4;
          lamp_d  = LAMPS_SAFE;
          blink_d = 8'd0;
        end
      end
      default: begin
        if (ACK && !viol) begin
          state_d = S_NORMAL;
          code_d  = 3'd0;
          deb_d   = 4'd0;
        end else begin
          if (blink_q == BLINK_LAST) begin
            blink_d = 8'd0;
            red_d   = ~lamp_q[3];
          end else begin
            blink_d = blink_q + 8'd1;
          end
          lamp_d = {2'b00, red_d, 2'b00, red_d};
        end
      end
    endcase
  end

`ifdef TL_MON_FAULT_COUNT_EN
  logic fault_entry;
  assign fault_entry = (state_q == S_NORMAL) && (state_d == S_FAULT);
`endif

  always_ff @(posedge clk) begin
    if (!CLRN) begin
      state_q <= S_NORMAL;
      lamp_q  <= LAMPS_SAFE;
      code_q  <= 3'd0;
      deb_q   <= 4'd0;
      age1_q  <= 4'd0;
      age2_q  <= 4'd0;
      blink_q <= 8'd0;
`ifdef TL_MON_FAULT_COUNT_EN
      FCOUNT  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      code_q  <= code_d;
      deb_q   <= deb_d;
      age1_q  <= age1_d;
      age2_q  <= age2_d;
      blink_q <= blink_d;
`ifdef TL_MON_FAULT_COUNT_EN
      if (fault_entry && FCOUNT != 8'hFF) FCOUNT <= FCOUNT + 8'd1;
`endif
    end
  end

  assign {OG1, OY1, OR1, OG2, OY2, OR2} = lamp_q;
  assign FAULT = (state_q == S_FAULT);
  assign FLASH = (state_q == S_FAULT);
  assign FCODE = code_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Scoreboard bench for tl_conflict_monitor: each driven cycle queues the expected registered outputs.
module tb_tl_conflict_monitor;

  logic clk = 1'b0;
  logic CLRN = 1'b0;
  logic GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b0;
  logic GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b0;
  logic ACK = 1'b0;
  logic OG1, OY1, OR1, OG2, OY2, OR2, FAULT, FLASH;
  logic [2:0] FCODE;
`ifdef TL_MON_FAULT_COUNT_EN
  logic [7:0] FCOUNT;
`endif

  tl_conflict_monitor dut (
    .clk(clk), .CLRN(CLRN),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .ACK(ACK),
    .OG1(OG1), .OY1(OY1), .OR1(OR1), .OG2(OG2), .OY2(OY2), .OR2(OR2),
    .FAULT(FAULT), .FCODE(FCODE), .FLASH(FLASH)
`ifdef TL_MON_FAULT_COUNT_EN
    , .FCOUNT(FCOUNT)
`endif
  );

  always #5 clk = ~clk;

  // Lamp patterns, bit order {g1, y1, r1, g2, y2, r2}.
  localparam logic [5:0] G1R2 = 6'b100_001;
  localparam logic [5:0] Y1R2 = 6'b010_001;
  localparam logic [5:0] R1R2 = 6'b001_001;
  localparam logic [5:0] R1G2 = 6'b001_100;
  localparam logic [5:0] G1G2 = 6'b100_100;
  localparam logic [5:0] A1DK = 6'b000_001;
  localparam logic [5:0] G1Y1 = 6'b110_000;
  localparam logic [5:0] A2DK = 6'b001_000;
  localparam logic [5:0] Y1DK = 6'b010_000;

  // Expected word: {lamps[5:0], fault, fcode[2:0], flash}.
  localparam logic [10:0] RST = {6'b001_001, 1'b0, 3'd0, 1'b0};

  typedef struct packed {
    logic [10:0] o;
    logic [7:0]  fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int nstep = 0;
  logic [7:0] efc = 8'd0;
  logic last_fault = 1'b0;

  function automatic logic [10:0] pass(input logic [5:0] l);
    return {l, 1'b0, 3'd0, 1'b0};
  endfunction

  function automatic logic [10:0] flt(input logic r, input logic [2:0] c);
    return {2'b00, r, 2'b00, r, 1'b1, c, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic clrn, input logic ack, input logic [5:0] l, input logic [10:0] e);
    exp_t x;
    @(negedge clk);
    CLRN = clrn;
    ACK  = ack;
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = l;
    if (!clrn) begin
      efc = 8'd0;
      last_fault = 1'b0;
    end else begin
      if (e[4] && !last_fault && efc != 8'hFF) efc = efc + 8'd1;
      last_fault = e[4];
    end
    x.o  = e;
    x.fc = efc;
    q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        nstep++;
        check($sformatf("out[%0d]", nstep),
              16'({OG1, OY1, OR1, OG2, OY2, OR2, FAULT, FCODE, FLASH}), 16'(x.o));
`ifdef TL_MON_FAULT_COUNT_EN
        check($sformatf("fcount[%0d]", nstep), 16'(FCOUNT), 16'(x.fc));
`endif
      end
    end
  end

  initial begin
    repeat (2) step(1'b0, 1'($urandom), 6'($urandom), RST);

    // pass-through
    repeat (3) step(1'b1, 1'b0, G1R2, pass(G1R2));
    step(1'b1, 1'b0, R1R2, pass(R1R2));
    step(1'b1, 1'b0, R1G2, pass(R1G2));
    step(1'b1, 1'b0, R1R2, pass(R1R2));

    // single-cycle conflict leaks through, ACK in NORMAL ignored
    step(1'b1, 1'b1, G1G2, pass(G1G2));
    step(1'b1, 1'b0, G1R2, pass(G1R2));

    // two-cycle conflict -> fault code 1, then blink 1111 0000 1
    step(1'b1, 1'b0, G1G2, pass(G1G2));
    step(1'b1, 1'b0, G1G2, flt(1'b1, 3'd1));
    repeat (2) step(1'b1, 1'b0, G1G2, flt(1'b1, 3'd1));
    step(1'b1, 1'b0, A1DK, flt(1'b1, 3'd1));
    repeat (4) step(1'b1, 1'b1, G1G2, flt(1'b0, 3'd1));
    step(1'b1, 1'b1, G1G2, flt(1'b1, 3'd1));
    step(1'b1, 1'b1, G1R2, pass(G1R2));
    step(1'b1, 1'b0, G1R2, pass(G1R2));

    // short yellow (2 cycles) -> code 4; immediate ACK exit
    repeat (2) step(1'b1, 1'b0, Y1R2, pass(Y1R2));
    step(1'b1, 1'b0, R1R2, flt(1'b1, 3'd4));
    step(1'b1, 1'b1, R1R2, pass(R1R2));

    // full-length yellow -> no fault
    step(1'b1, 1'b0, G1R2, pass(G1R2));
    repeat (3) step(1'b1, 1'b0, Y1R2, pass(Y1R2));
    step(1'b1, 1'b0, R1R2, pass(R1R2));

    // code 2 beats code 3; short yellow while in FAULT is ignored on exit
    step(1'b1, 1'b0, G1Y1, pass(G1Y1));
    step(1'b1, 1'b0, G1Y1, flt(1'b1, 3'd2));
    step(1'b1, 1'b1, R1R2, pass(R1R2));

    // code 3
    step(1'b1, 1'b0, A2DK, pass(A2DK));
    step(1'b1, 1'b0, A2DK, flt(1'b1, 3'd3));
    step(1'b1, 1'b1, R1R2, pass(R1R2));

    // static fault and short yellow on the same edge: static code wins
    step(1'b1, 1'b0, Y1DK, pass(Y1DK));
    step(1'b1, 1'b0, A2DK, flt(1'b1, 3'd3));
    step(1'b1, 1'b1, R1R2, pass(R1R2));

    // reset overrides FAULT
    step(1'b1, 1'b0, G1G2, pass(G1G2));
    step(1'b1, 1'b0, G1G2, flt(1'b1, 3'd1));
    step(1'b0, 1'b0, G1G2, RST);
    step(1'b1, 1'b0, R1R2, pass(R1R2));

    repeat (2) @(posedge clk);
    #2;
    check("drain", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
